// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: default widths,
// the access-timeout limit and the FSM state encoding.
package mem_access_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } state_e;

  // Counter width able to hold values 0 .. limit-1.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory access: synchronous clear, count
// enable, and a terminal-count flag when the count reaches LIMIT-1.
// The count saturates at LIMIT-1 so it can never wrap back to zero.
module mem_wait_timer #(
  parameter int LIMIT = 16,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc = (count_q == CNT_W'(LIMIT - 1));

  // Next count: clear has priority, otherwise advance until terminal count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results straight to write-back, and for
// loads/stores issues one registered request to data memory, stalls the
// upstream pipeline until mem_ack, and latches a sticky error when the
// memory fails to answer within TIMEOUT access cycles.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] dbusIn,
  input  logic [DATA_W-1:0] bOperandIn,
  input  logic [DATA_W-1:0] dSelIn,
  input  logic              storeValIn,
  input  logic              loadValIn,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] wbDataOut,
  output logic [DATA_W-1:0] dSelOut,
  output logic              wbValidOut,
  output logic              memErr
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] dsel_cap_q, dsel_cap_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] dsel_out_q, dsel_out_d;
  logic              wb_valid_q, wb_valid_d;
  logic              mem_err_q, mem_err_d;

  logic timer_clr;
  logic timer_en;
  logic timer_tc;

  mem_wait_timer #(
    .LIMIT (TIMEOUT),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr    (timer_clr),
    .en     (timer_en),
    .tc     (timer_tc)
  );

  // Next-state and next-output logic; every register holds by default.
  // The store flag held in mem_we_q doubles as the captured op type.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dsel_cap_d  = dsel_cap_q;
    wb_data_d   = wb_data_q;
    dsel_out_d  = dsel_out_q;
    wb_valid_d  = wb_valid_q;
    mem_err_d   = mem_err_q;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Keep the timer at zero so it starts fresh on entry to ACCESS.
        timer_clr = 1'b1;
        if (storeValIn || loadValIn) begin
          state_d     = ST_ACCESS;
          mem_req_d   = 1'b1;
          mem_we_d    = storeValIn;
          mem_addr_d  = dbusIn;
          mem_wdata_d = bOperandIn;
          dsel_cap_d  = dSelIn;
          wb_valid_d  = 1'b0;
        end else begin
          wb_data_d  = dbusIn;
          dsel_out_d = dSelIn;
          wb_valid_d = |dSelIn;
        end
      end

      ST_ACCESS: begin
        wb_valid_d = 1'b0;
        if (mem_ack) begin
          // An ack in the timeout cycle still completes normally.
          if (!mem_we_q) begin
            wb_data_d  = mem_rdata;
            dsel_out_d = dsel_cap_q;
            wb_valid_d = |dsel_cap_q;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_IDLE;
        end else if (timer_tc) begin
          mem_err_d = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_ERR;
        end else begin
          timer_en = 1'b1;
        end
      end

      ST_ERR: begin
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        wb_valid_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dsel_cap_q  <= '0;
      wb_data_q   <= '0;
      dsel_out_q  <= '0;
      wb_valid_q  <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dsel_cap_q  <= dsel_cap_d;
      wb_data_q   <= wb_data_d;
      dsel_out_q  <= dsel_out_d;
      wb_valid_q  <= wb_valid_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign stall      = (state_q != ST_IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wbDataOut  = wb_data_q;
  assign dSelOut    = dsel_out_q;
  assign wbValidOut = wb_valid_q;
  assign memErr     = mem_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a transaction-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_mem_access;

  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] dbusIn, bOperandIn, dSelIn, mem_rdata;
  logic          storeValIn, loadValIn, mem_ack;
  logic          mem_req, mem_we, stall, wbValidOut, memErr;
  logic [DW-1:0] mem_addr, mem_wdata, wbDataOut, dSelOut;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mem_access #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .dbusIn     (dbusIn),
    .bOperandIn (bOperandIn),
    .dSelIn     (dSelIn),
    .storeValIn (storeValIn),
    .loadValIn  (loadValIn),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall      (stall),
    .wbDataOut  (wbDataOut),
    .dSelOut    (dSelOut),
    .wbValidOut (wbValidOut),
    .memErr     (memErr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy, m_err, m_load;
  int          m_waited;
  logic [31:0] m_dsel;
  logic        e_req, e_we, e_valid;
  logic [31:0] e_addr, e_wdata, e_wb, e_dsel;

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy = 0; m_err = 0; m_load = 0; m_waited = 0; m_dsel = 0;
      e_req = 0; e_we = 0; e_valid = 0;
      e_addr = 0; e_wdata = 0; e_wb = 0; e_dsel = 0;
    end else if (m_err) begin
      e_req = 0; e_we = 0; e_valid = 0;
    end else if (!m_busy) begin
      if (loadValIn || storeValIn) begin
        m_busy = 1; m_waited = 0;
        m_load = !storeValIn;
        m_dsel = dSelIn;
        e_req = 1; e_we = storeValIn;
        e_addr = dbusIn; e_wdata = bOperandIn;
        e_valid = 0;
      end else begin
        e_wb = dbusIn; e_dsel = dSelIn; e_valid = (dSelIn != 0);
      end
    end else begin
      e_valid = 0;
      if (mem_ack) begin
        if (m_load) begin
          e_wb = mem_rdata; e_dsel = m_dsel; e_valid = (m_dsel != 0);
        end
        e_req = 0; e_we = 0; m_busy = 0;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_err = 1; m_busy = 0; e_req = 0; e_we = 0;
        end
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp mem_req", 32'(mem_req), 32'(e_req));
      chk("cmp mem_we", 32'(mem_we), 32'(e_we));
      chk("cmp mem_addr", mem_addr, e_addr);
      chk("cmp mem_wdata", mem_wdata, e_wdata);
      chk("cmp wbDataOut", wbDataOut, e_wb);
      chk("cmp dSelOut", dSelOut, e_dsel);
      chk("cmp wbValidOut", 32'(wbValidOut), 32'(e_valid));
      chk("cmp memErr", 32'(memErr), 32'(m_err));
      chk("cmp stall", 32'(stall), 32'(m_busy || m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] d);
    loadValIn = ld; storeValIn = st; dbusIn = a; bOperandIn = b; dSelIn = d;
  endtask

  task automatic clr_op();
    loadValIn = 0; storeValIn = 0; dbusIn = 0; bOperandIn = 0; dSelIn = 0;
  endtask

  initial begin
    resetn = 0; mem_ack = 0; mem_rdata = 0;
    clr_op();
    repeat (2) tick();
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset memErr", 32'(memErr), 32'd0);
    chk("reset wbValid", 32'(wbValidOut), 32'd0);
    chk("reset wbData", wbDataOut, 32'd0);
    resetn = 1;
    cmp_en = 1;
    tick();

    // ALU pass-through
    set_op(0, 0, 32'h10, 32'h0, 32'h8);
    tick();
    chk("alu wbData", wbDataOut, 32'h10);
    chk("alu dSel", dSelOut, 32'h8);
    chk("alu valid", 32'(wbValidOut), 32'd1);
    chk("alu stall", 32'(stall), 32'd0);
    $display("txn alu   data=0x%08h dsel=0x%08h", wbDataOut, dSelOut);

    // Load, ack in the first ACCESS cycle
    set_op(1, 0, 32'h40, 32'h0, 32'h4);
    tick();
    chk("ld req", 32'(mem_req), 32'd1);
    chk("ld we", 32'(mem_we), 32'd0);
    chk("ld addr", mem_addr, 32'h40);
    chk("ld stall1", 32'(stall), 32'd1);
    clr_op();
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 0;
    chk("ld stall2", 32'(stall), 32'd0);
    chk("ld wbData", wbDataOut, 32'hDEAD_BEEF);
    chk("ld dSel", dSelOut, 32'h4);
    chk("ld valid", 32'(wbValidOut), 32'd1);
    $display("txn load  addr=0x40 data=0x%08h", wbDataOut);

    // Store, ack in the third ACCESS cycle
    set_op(0, 1, 32'h44, 32'h1234, 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      clr_op();
      chk("st we", 32'(mem_we), 32'd1);
      chk("st addr", mem_addr, 32'h44);
      chk("st data", mem_wdata, 32'h1234);
      chk("st stall", 32'(stall), 32'd1);
      chk("st valid", 32'(wbValidOut), 32'd0);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("st done stall", 32'(stall), 32'd0);
    chk("st done req", 32'(mem_req), 32'd0);
    chk("st done valid", 32'(wbValidOut), 32'd0);
    $display("txn store addr=0x44 data=0x1234");

    // Load acked in the 16th ACCESS cycle: no error
    set_op(1, 0, 32'h90, 32'h0, 32'h1);
    tick();
    clr_op();
    repeat (TMO - 1) tick();
    chk("late req", 32'(mem_req), 32'd1);
    mem_ack = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ack = 0;
    chk("late err", 32'(memErr), 32'd0);
    chk("late wbData", wbDataOut, 32'hCAFE_0001);
    chk("late valid", 32'(wbValidOut), 32'd1);
    $display("txn load  late ack data=0x%08h", wbDataOut);

    // Load with no ack: timeout after 16 ACCESS cycles
    set_op(1, 0, 32'h80, 32'h0, 32'h1);
    tick();
    clr_op();
    repeat (TMO - 1) tick();
    chk("tmo err early", 32'(memErr), 32'd0);
    chk("tmo req early", 32'(mem_req), 32'd1);
    tick();
    chk("tmo err", 32'(memErr), 32'd1);
    chk("tmo req", 32'(mem_req), 32'd0);
    chk("tmo stall", 32'(stall), 32'd1);
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    set_op(0, 0, 32'h77, 32'h0, 32'h1);
    tick();
    mem_ack = 0;
    clr_op();
    chk("err valid", 32'(wbValidOut), 32'd0);
    chk("err stall", 32'(stall), 32'd1);
    chk("err sticky", 32'(memErr), 32'd1);
    $display("txn load  timeout memErr=%0d", memErr);
    resetn = 0;
    tick();
    resetn = 1;
    chk("err reset", 32'(memErr), 32'd0);
    chk("err reset stall", 32'(stall), 32'd0);

    // Reset in the second ACCESS cycle abandons the load
    set_op(1, 0, 32'hA0, 32'h0, 32'h2);
    tick();
    clr_op();
    tick();
    resetn = 0;
    tick();
    chk("rst req", 32'(mem_req), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst err", 32'(memErr), 32'd0);
    resetn = 1;
    mem_ack = 1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_ack = 0;
    chk("rst no wb", 32'(wbValidOut), 32'd0);
    $display("txn load  aborted by reset");

    // Load and store both set: treated as store
    set_op(1, 1, 32'h50, 32'h77, 32'h10);
    tick();
    clr_op();
    chk("both we", 32'(mem_we), 32'd1);
    chk("both wdata", mem_wdata, 32'h77);
    mem_ack = 1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 0;
    chk("both no wb", 32'(wbValidOut), 32'd0);
    $display("txn both  treated as store");

    tick();
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
